// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
//
// ID stage of a five-stage MIPS-style pipeline. It decodes the IF/ID
// instruction, reads two operands from a 32 x 32 register file (with
// same-cycle writeback bypass), resolves beq in this stage, detects load-use
// and branch-operand hazards, and latches the result into the ID/EX register.
// All state updates happen on the falling edge of clk.
//
// Ports
//   clk, reset                 falling-edge clock, async active-high reset
//   instruction, programCounter  IF/ID instruction and its PC
//   writeEnable, writeRegister, writeData  writeback port
//   exMemRegWrite, exMemDest   EX/MEM destination, for branch hazards
//   pcWrite, ifIdWrite         fetch enables, low while stalling
//   branch, branchProgramCounter  taken-branch select and target
//   idEx*                      ID/EX pipeline register outputs
// -----------------------------------------------------------------------------
module instruction_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] programCounter,
  input  logic        writeEnable,
  input  logic [4:0]  writeRegister,
  input  logic [31:0] writeData,
  input  logic        exMemRegWrite,
  input  logic [4:0]  exMemDest,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        branch,
  output logic [31:0] branchProgramCounter,
  output logic [31:0] idExReadData1,
  output logic [31:0] idExReadData2,
  output logic [31:0] idExImmediate,
  output logic [4:0]  idExRs,
  output logic [4:0]  idExRt,
  output logic [4:0]  idExDest,
  output logic        idExRegWrite,
  output logic        idExMemRead,
  output logic        idExMemWrite,
  output logic        idExAluSrc,
  output logic [2:0]  idExAluOp
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } aluOpT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] immediate;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        aluSrc;
    aluOpT       aluOp;
  } idExT;

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] signExtImm;
  logic        unusedShamt;

  assign opcode      = instruction[31:26];
  assign rs          = instruction[25:21];
  assign rt          = instruction[20:16];
  assign rd          = instruction[15:11];
  assign funct       = instruction[5:0];
  assign signExtImm  = {{16{instruction[15]}}, instruction[15:0]};
  assign unusedShamt = ^instruction[10:6];

  // ---------------------------------------------------------------------------
  // Register file: two asynchronous read ports, one falling-edge write port.
  // ---------------------------------------------------------------------------
  logic [31:0] regFile [32];
  logic [31:0] rsValue;
  logic [31:0] rtValue;

  // NOTE: the array is reset explicitly because the pipeline contract is that
  // every register reads 0 after reset; that rules out a plain RAM macro.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (writeEnable && (writeRegister != 5'd0)) begin
      regFile[writeRegister] <= writeData;
    end
  end

  // Writeback data lands on the same edge that latches ID/EX, so forward it
  // here to make the value visible to the instruction being decoded now.
  always_comb begin
    if (rs == 5'd0)                                      rsValue = '0;
    else if (writeEnable && (writeRegister == rs))       rsValue = writeData;
    else                                                 rsValue = regFile[rs];
    if (rt == 5'd0)                                      rtValue = '0;
    else if (writeEnable && (writeRegister == rt))       rtValue = writeData;
    else                                                 rtValue = regFile[rt];
  end

  // ---------------------------------------------------------------------------
  // Decode. Unsupported encodings leave the bundle all-zero, i.e. a bubble.
  // ---------------------------------------------------------------------------
  idExT decoded;
  logic isBeq;
  logic usesRt;

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    decoded = '0;
    isBeq   = 1'b0;
    usesRt  = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        usesRt = 1'b1;
        case (funct)
          FN_ADD:  begin decoded.regWrite = 1'b1; decoded.aluOp = ALU_ADD; end
          FN_SUB:  begin decoded.regWrite = 1'b1; decoded.aluOp = ALU_SUB; end
          FN_AND:  begin decoded.regWrite = 1'b1; decoded.aluOp = ALU_AND; end
          FN_OR:   begin decoded.regWrite = 1'b1; decoded.aluOp = ALU_OR;  end
          FN_SLT:  begin decoded.regWrite = 1'b1; decoded.aluOp = ALU_SLT; end
          default: decoded = '0;
        endcase
        if (decoded.regWrite) decoded.dest = rd;
      end
      OP_ADDI: begin
        decoded.regWrite = 1'b1;
        decoded.aluSrc   = 1'b1;
        decoded.dest     = rt;
      end
      OP_LW: begin
        decoded.regWrite = 1'b1;
        decoded.memRead  = 1'b1;
        decoded.aluSrc   = 1'b1;
        decoded.dest     = rt;
      end
      OP_SW: begin
        usesRt           = 1'b1;
        decoded.memWrite = 1'b1;
        decoded.aluSrc   = 1'b1;
      end
      OP_BEQ: begin
        usesRt = 1'b1;
        isBeq  = 1'b1;
      end
      default: decoded = '0;
    endcase
    // Operand fields travel only with recognised instructions.
    if (decoded.regWrite || decoded.memWrite || isBeq) begin
      decoded.readData1 = rsValue;
      decoded.readData2 = rtValue;
      decoded.immediate = signExtImm;
      decoded.rs        = rs;
      decoded.rt        = rt;
    end
  end

  // ---------------------------------------------------------------------------
  // Hazards, branch resolution, squash.
  // ---------------------------------------------------------------------------
  idExT idExQ;
  logic squash;
  logic loadUse;
  logic branchHazard;
  logic stall;
  logic branchTaken;

  always_comb begin
    loadUse = idExQ.memRead && (idExQ.dest != 5'd0) &&
              ((idExQ.dest == rs) || (usesRt && (idExQ.dest == rt)));
    branchHazard = isBeq && (
      (idExQ.regWrite && (idExQ.dest != 5'd0) &&
       ((idExQ.dest == rs) || (idExQ.dest == rt))) ||
      (exMemRegWrite && (exMemDest != 5'd0) &&
       ((exMemDest == rs) || (exMemDest == rt))));
    // A squashed slot is discarded anyway, so it must never hold up fetch.
    stall       = (loadUse || branchHazard) && !squash && !reset;
    branchTaken = isBeq && !stall && !squash && !reset && (rsValue == rtValue);
  end

  assign pcWrite              = !stall;
  assign ifIdWrite            = !stall;
  assign branch               = branchTaken;
  assign branchProgramCounter = programCounter + 32'd4 + {signExtImm[29:0], 2'b00};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      idExQ  <= '0;
      squash <= 1'b0;
    end else begin
      idExQ  <= (stall || squash) ? idExT'('0) : decoded;
      squash <= branchTaken;
    end
  end

  assign idExReadData1 = idExQ.readData1;
  assign idExReadData2 = idExQ.readData2;
  assign idExImmediate = idExQ.immediate;
  assign idExRs        = idExQ.rs;
  assign idExRt        = idExQ.rt;
  assign idExDest      = idExQ.dest;
  assign idExRegWrite  = idExQ.regWrite;
  assign idExMemRead   = idExQ.memRead;
  assign idExMemWrite  = idExQ.memWrite;
  assign idExAluSrc    = idExQ.aluSrc;
  assign idExAluOp     = idExQ.aluOp;

endmodule
